serial_arithmetic_unit: RTL
===========================

// Module: serial_arithmetic_unit
//
// PURPOSE
//   Multi-bit arithmetic unit that processes WIDTH-bit operands DIGIT bits per clock, LSB first.
//   It uses the 3-bit {operation, carry_in} code: the carry ripples through a register between beats.
//   It sits between the operand/decode stage and the register writeback of the ALU.
//   Valid/ready handshakes sit on both sides. It adds carry_out, signed overflow and zero flags.
//
// PARAMETERS
//   WIDTH  8  operand/result width in bits
//   DIGIT  1  bits processed per cycle; WIDTH % DIGIT == 0, otherwise $fatal at elaboration
//   (derived) BEATS = WIDTH/DIGIT cycles per operation
//
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands and code valid
//   in_ready   out  1      unit idle; can accept operands
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   operation  in   2      B-term select: 00 zero, 01 B, 10 ~B, 11 all-ones
//   carry_in   in   1      initial carry into bit 0
//   out_valid  out  1      result and flags valid
//   out_ready  in   1      consumer accepts result
//   out        out  WIDTH  result = A + Bterm + carry_in (mod 2^WIDTH)
//   carry_out  out  1      carry out of bit WIDTH-1
//   overflow   out  1      carry into MSB XOR carry out of MSB (two's-complement overflow)
//   zero       out  1      out == 0
//
// BEHAVIOUR
//   - Reset (async assert, sync release):
//     - in_ready=1; out_valid=0; out, carry_out, overflow and zero = 0.
//     - FSM returns to IDLE and the beat counter clears.
//     - Reset asserted mid-operation aborts the operation; nothing is emitted.
//   - Codes {operation, carry_in}:
//     - 000 A; 001 A+1; 010 A+B; 011 A+B+1.
//     - 100 A+~B; 101 A-B; 110 A-1; 111 A, with carry_out=1.
//   - FSM IDLE -> BUSY -> DONE -> IDLE.
//     - IDLE: in_ready=1. When in_valid && in_ready at an edge:
//       - capture a, b, operation and carry_in; carry register <= carry_in;
//       - go to BUSY.
//       - Inputs need not stay stable after the accepting edge.
//     - BUSY: in_ready=0. Each edge adds the low DIGIT bits of A, the B-term and the carry register.
//       - The DIGIT sum bits shift into the result register from the top.
//       - The carry register updates; the beat counter increments.
//       - The final beat also records carry into the MSB.
//       - On the BEATS-th BUSY edge go to DONE.
//     - DONE: out_valid=1. out, carry_out, overflow and zero are held stable.
//       - When out_valid && out_ready at an edge, go to IDLE; out_valid=0 and in_ready=1 from the next cycle.
//   - Latency and throughput:
//     - out_valid rises exactly BEATS cycles after the accepting edge.
//     - Max throughput: one operation per BEATS+2 cycles.
//     - No accept is made in the same cycle as a result handshake.
//   - in_valid is ignored outside IDLE. operand changes while BUSY/DONE have no effect.
//   - out, carry_out, overflow and zero hold their last values after the handshake until the next completion.
//   - Code 000 always gives carry_out=0 and overflow=0.
//   - DIGIT==WIDTH (BEATS=1) is legal: single-beat operation with the same handshake timing.
//
// STRUCTURE
//   - Package arithmetic_pkg:
//     - typedef enum logic [1:0] arith_sel_e {ARITH_PASS, ARITH_ADD, ARITH_ADD_NOT_B, ARITH_DEC};
//     - typedef enum logic [1:0] serial_state_e {S_IDLE, S_BUSY, S_DONE}.
//   - Sub-module arithmetic_digit: combinational DIGIT-bit adder.
//     - Inputs: a, bterm, cin.
//     - Outputs: sum, cout, and carry into the top bit (for overflow).
//     - Instantiated once.
//   - The top level holds the FSM, beat counter ($clog2(BEATS+1) bits), A/B shift registers,
//     carry register and result register.
//
// TESTING (WIDTH=8, DIGIT=2 unless noted)
//   1. Reset: drop rst_n while BUSY.
//      -> immediately out_valid=0, in_ready=1, out=0;
//      -> after release, the next accept completes normally.
//   2. ADD: a=8'h7F, b=8'h01, code 010.
//      -> out=8'h80, carry_out=0, overflow=1, zero=0;
//      -> out_valid exactly 4 cycles after accept.
//   3. SUB: a=8'h05, b=8'h05, code 101.
//      -> out=8'h00, carry_out=1, zero=1, overflow=0.
//   4. DEC wrap: a=8'h00, code 110 -> out=8'hFF, carry_out=0.
//      Code 111 with a=8'h3C -> out=8'h3C, carry_out=1.
//   5. Backpressure: hold out_ready=0 for 10 cycles.
//      -> outputs stable and in_ready=0; in_valid with new operands is ignored.
//      Release out_ready -> in_ready=1 next cycle, and the next operation is accepted.
//   6. Random: 1000 operations, all 8 codes, random valid/ready, compared against a golden model.
//      Repeat with DIGIT=1 and DIGIT=8.

Source files
------------

// File: rtl/arithmetic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arithmetic_pkg
// Description : Shared types for the serial arithmetic unit: the B-term
//               select encoding (the 'operation' field) and the sequencer
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package arithmetic_pkg;

    // B-term select; the encoding matches the 2-bit 'operation' input.
    typedef enum logic [1:0] {
        ARITH_PASS      = 2'b00,  // B-term = 0
        ARITH_ADD       = 2'b01,  // B-term = B
        ARITH_ADD_NOT_B = 2'b10,  // B-term = ~B
        ARITH_DEC       = 2'b11   // B-term = all ones
    } arith_sel_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } serial_state_e;

endpackage : arithmetic_pkg
`default_nettype wire

// File: rtl/arithmetic_digit.sv
`default_nettype none
// ============================================================================
// Module      : arithmetic_digit
// Description : Combinational DIGIT-bit ripple adder used for one beat of
//               the serial arithmetic unit.
// Ports       : a     [DIGIT] in  - operand A digit
//               bterm [DIGIT] in  - selected B-term digit
//               cin   [1]     in  - carry into bit 0 of the digit
//               sum   [DIGIT] out - digit sum
//               cout  [1]     out - carry out of the top bit of the digit
//               ctop  [1]     out - carry into the top bit of the digit
// Revision    : 1.0 - initial release
// ============================================================================
module arithmetic_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] bterm,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             ctop
);

    // w_carry[i] is the carry into bit i; the top-bit carry-in is kept so the
    // caller can form signed overflow on the last beat.
    logic [DIGIT:0] w_carry;

    always_comb begin
        w_carry    = '0;
        sum        = '0;
        w_carry[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]       = a[i] ^ bterm[i] ^ w_carry[i];
            w_carry[i+1] = (a[i] & bterm[i]) | (a[i] & w_carry[i]) | (bterm[i] & w_carry[i]);
        end
    end

    assign cout = w_carry[DIGIT];
    assign ctop = w_carry[DIGIT-1];

endmodule : arithmetic_digit
`default_nettype wire

// File: rtl/serial_arithmetic_unit.sv
`default_nettype none
// ============================================================================
// Module      : serial_arithmetic_unit
// Description : Digit-serial adder/subtractor. Processes WIDTH-bit operands
//               DIGIT bits per clock, LSB first, computing
//               A + Bterm + carry_in with carry, overflow and zero flags.
//               Valid/ready handshakes on both the operand and result sides.
// Ports       : clk       in   1     rising-edge clock
//               rst_n     in   1     asynchronous active-low reset
//               in_valid  in   1     operands and code valid
//               in_ready  out  1     unit idle, operands can be accepted
//               a, b      in   WIDTH operands
//               operation in   2     B-term select (see arith_sel_e)
//               carry_in  in   1     carry into bit 0
//               out_valid out  1     result and flags valid
//               out_ready in   1     consumer accepts result
//               out       out  WIDTH result
//               carry_out out  1     carry out of the MSB
//               overflow  out  1     two's-complement overflow
//               zero      out  1     result is zero
// Revision    : 1.0 - initial release
// ============================================================================
module serial_arithmetic_unit
    import arithmetic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       operation,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int BEATS = WIDTH / DIGIT;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(BEATS - 1);

    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
        $fatal(1, "serial_arithmetic_unit: WIDTH must be a positive multiple of DIGIT");
    end

    serial_state_e    r_state;
    serial_state_e    w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    arith_sel_e       r_sel;
    logic             r_carry;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_out;
    logic             r_carry_out;
    logic             r_overflow;
    logic             r_zero;

    logic [DIGIT-1:0]       w_bterm;
    logic [DIGIT-1:0]       w_sum;
    logic                   w_cout;
    logic                   w_ctop;
    logic                   w_last_beat;
    logic [WIDTH+DIGIT-1:0] w_acc_cat;
    logic [WIDTH-1:0]       w_acc_next;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_last_beat = (r_cnt == c_last_beat);

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_last_beat) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Beat datapath
    // ------------------------------------------------------------------
    always_comb begin
        case (r_sel)
            ARITH_PASS:      w_bterm = '0;
            ARITH_ADD:       w_bterm = r_b[DIGIT-1:0];
            ARITH_ADD_NOT_B: w_bterm = ~r_b[DIGIT-1:0];
            ARITH_DEC:       w_bterm = '1;
            default:         w_bterm = '0;
        endcase
    end

    arithmetic_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a     (r_a[DIGIT-1:0]),
        .bterm (w_bterm),
        .cin   (r_carry),
        .sum   (w_sum),
        .cout  (w_cout),
        .ctop  (w_ctop)
    );

    // New digits enter at the top so that after BEATS beats the first
    // (least significant) digit has reached bit 0. Concatenating and slicing
    // keeps this legal when DIGIT == WIDTH.
    assign w_acc_cat  = {w_sum, r_acc};
    assign w_acc_next = w_acc_cat[WIDTH+DIGIT-1:DIGIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sel       <= ARITH_PASS;
            r_carry     <= 1'b0;
            r_acc       <= '0;
            r_out       <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sel   <= arith_sel_e'(operation);
                        r_carry <= carry_in;
                        r_cnt   <= '0;
                    end
                end
                S_BUSY: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_cout;
                    r_acc   <= w_acc_next;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    // Published results live in their own registers so they
                    // stay put while the next operation is being shifted in.
                    if (w_last_beat) begin
                        r_out       <= w_acc_next;
                        r_carry_out <= w_cout;
                        r_overflow  <= w_ctop ^ w_cout;
                        r_zero      <= (w_acc_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out       = r_out;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

endmodule : serial_arithmetic_unit
`default_nettype wire
